efgh_round_engine: RTL and testbench

- Iterative SHA-2 e/f/g/h half-round engine.
- Holds the e,f,g,h working words and performs one compression round per accepted round beat.
- Each round emits T1 for the companion a/b/c/d half. After NROUNDS accepted beats it presents the final e,f,g,h.
- Generalises the single-round efgh datapath to SHA-256/SHA-512 word widths, adds a round counter, a start/done FSM and a round-input valid handshake.

---
 rtl/efgh_round_engine.sv | 142 ++++++++++++++
 tb/tb_efgh_round_engine.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/efgh_round_engine.sv
// Iterative SHA-2 e/f/g/h half-round engine: one compression round per accepted kw beat.
// Optional build macro EFGH_FEEDFORWARD_EN adds the init words back into efgh_out (Davies-Meyer).
module efgh_round_engine #(
    parameter int WORD_W  = 32,
    parameter int NROUNDS = 64,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*WORD_W-1:0]   init_efgh,
    input  logic                  kw_valid,
    input  logic [WORD_W-1:0]     kw,
    input  logic [WORD_W-1:0]     d,
    output logic                  kw_ready,
    output logic                  t1_valid,
    output logic [WORD_W-1:0]     t1,
    output logic [CNT_W-1:0]      round_idx,
    output logic                  busy,
    output logic                  done,
    output logic [4*WORD_W-1:0]   efgh_out
);

    generate
        if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
            $error("efgh_round_engine: WORD_W must be 32 or 64");
        end
        if (NROUNDS < 1 || NROUNDS > 255) begin : g_bad_nrounds
            $error("efgh_round_engine: NROUNDS must be in 1..255");
        end
        if ((1 << CNT_W) <= NROUNDS) begin : g_bad_cnt_w
            $error("efgh_round_engine: CNT_W too narrow for NROUNDS");
        end
    endgenerate

    // Big-sigma-1 rotation amounts: SHA-256 uses 6/11/25, SHA-512 uses 14/18/41.
    localparam int ROT_A = (WORD_W == 64) ? 14 : 6;
    localparam int ROT_B = (WORD_W == 64) ? 18 : 11;
    localparam int ROT_C = (WORD_W == 64) ? 41 : 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WORD_W-1:0]  e_q, f_q, g_q, h_q;

    logic [WORD_W-1:0]  sigma1;
    logic [WORD_W-1:0]  ch;
    logic [WORD_W-1:0]  t1_next;
    logic [WORD_W-1:0]  e_next;
    logic               last_beat;
    logic [4*WORD_W-1:0] final_efgh;

    assign sigma1 = ((e_q >> ROT_A) | (e_q << (WORD_W - ROT_A)))
                  ^ ((e_q >> ROT_B) | (e_q << (WORD_W - ROT_B)))
                  ^ ((e_q >> ROT_C) | (e_q << (WORD_W - ROT_C)));
    assign ch        = (e_q & f_q) ^ (~e_q & g_q);
    assign t1_next   = h_q + kw + sigma1 + ch;
    assign e_next    = d + t1_next;
    assign last_beat = (cnt == CNT_W'(NROUNDS - 1));

`ifdef EFGH_FEEDFORWARD_EN
    logic [4*WORD_W-1:0] init_q;

    // Final words are the post-round values, summed word-wise with the block's starting words.
    assign final_efgh = {e_next + init_q[4*WORD_W-1:3*WORD_W],
                         e_q    + init_q[3*WORD_W-1:2*WORD_W],
                         f_q    + init_q[2*WORD_W-1:WORD_W],
                         g_q    + init_q[WORD_W-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q <= '0;
        end else if (state == IDLE && start) begin
            init_q <= init_efgh;
        end
    end
`else
    assign final_efgh = {e_next, e_q, f_q, g_q};
`endif

    assign kw_ready = (state == RUN);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register here is a plain flop (no memory array), so all of it is cleared on reset.
            state     <= IDLE;
            cnt       <= '0;
            e_q       <= '0;
            f_q       <= '0;
            g_q       <= '0;
            h_q       <= '0;
            t1        <= '0;
            round_idx <= '0;
            t1_valid  <= 1'b0;
            done      <= 1'b0;
            efgh_out  <= '0;
        end else begin
            // NOTE: pulses default low each cycle; non-blocking so every branch sees pre-edge state.
            t1_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        {e_q, f_q, g_q, h_q} <= init_efgh;
                        cnt                  <= '0;
                        state                <= RUN;
                    end
                end
                RUN: begin
                    if (kw_valid) begin
                        e_q       <= e_next;
                        f_q       <= e_q;
                        g_q       <= f_q;
                        h_q       <= g_q;
                        t1        <= t1_next;
                        round_idx <= cnt;
                        t1_valid  <= 1'b1;
                        cnt       <= cnt + 1'b1;
                        if (last_beat) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            efgh_out <= final_efgh;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_efgh_round_engine.sv
// Directed bench for efgh_round_engine: SHA-256/SHA-512 "abc" blocks from a reference model,
// start/idle/reset corner cases, and an NROUNDS=1 instance.
module tb_efgh_round_engine;

    localparam logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc2a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [63:0] IV512 [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         kw_valid;
    logic [255:0] init;
    logic [63:0]  kw;
    logic [63:0]  dw;
    int           sel;

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    // Instance A: SHA-256, 64 rounds.
    logic         a_start, a_kv, a_ready, a_t1v, a_busy, a_done;
    logic [31:0]  a_t1;
    logic [7:0]   a_idx;
    logic [127:0] a_efgh;
    // Instance B: SHA-512, 80 rounds.
    logic         b_start, b_kv, b_ready, b_t1v, b_busy, b_done;
    logic [63:0]  b_t1;
    logic [7:0]   b_idx;
    logic [255:0] b_efgh;
    // Instance C: SHA-256 words, single round.
    logic         c_start, c_kv, c_ready, c_t1v, c_busy, c_done;
    logic [31:0]  c_t1;
    logic [7:0]   c_idx;
    logic [127:0] c_efgh;

    assign a_start = start && (sel == 0);
    assign a_kv    = kw_valid && (sel == 0);
    assign b_start = start && (sel == 1);
    assign b_kv    = kw_valid && (sel == 1);
    assign c_start = start && (sel == 2);
    assign c_kv    = kw_valid && (sel == 2);

    efgh_round_engine #(.WORD_W(32), .NROUNDS(64), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .init_efgh(init[127:0]),
        .kw_valid(a_kv), .kw(kw[31:0]), .d(dw[31:0]), .kw_ready(a_ready),
        .t1_valid(a_t1v), .t1(a_t1), .round_idx(a_idx), .busy(a_busy),
        .done(a_done), .efgh_out(a_efgh)
    );

    efgh_round_engine #(.WORD_W(64), .NROUNDS(80), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .init_efgh(init),
        .kw_valid(b_kv), .kw(kw), .d(dw), .kw_ready(b_ready),
        .t1_valid(b_t1v), .t1(b_t1), .round_idx(b_idx), .busy(b_busy),
        .done(b_done), .efgh_out(b_efgh)
    );

    efgh_round_engine #(.WORD_W(32), .NROUNDS(1), .CNT_W(8)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .init_efgh(init[127:0]),
        .kw_valid(c_kv), .kw(kw[31:0]), .d(dw[31:0]), .kw_ready(c_ready),
        .t1_valid(c_t1v), .t1(c_t1), .round_idx(c_idx), .busy(c_busy),
        .done(c_done), .efgh_out(c_efgh)
    );

    logic         rdy_s, t1v_s, busy_s, done_s;
    logic [63:0]  t1_s;
    logic [7:0]   idx_s;
    logic [255:0] efgh_s;

    always_comb begin
        rdy_s  = a_ready;
        t1v_s  = a_t1v;
        busy_s = a_busy;
        done_s = a_done;
        t1_s   = {32'b0, a_t1};
        idx_s  = a_idx;
        efgh_s = {128'b0, a_efgh};
        if (sel == 1) begin
            rdy_s  = b_ready;
            t1v_s  = b_t1v;
            busy_s = b_busy;
            done_s = b_done;
            t1_s   = b_t1;
            idx_s  = b_idx;
            efgh_s = b_efgh;
        end else if (sel == 2) begin
            rdy_s  = c_ready;
            t1v_s  = c_t1v;
            busy_s = c_busy;
            done_s = c_done;
            t1_s   = {32'b0, c_t1};
            idx_s  = c_idx;
            efgh_s = {128'b0, c_efgh};
        end
    end

    // ---------------- reference model (full SHA-2 compression of the "abc" block) ----------------
    bit          m512;
    logic [63:0] m_kw  [80];
    logic [63:0] m_d   [80];
    logic [63:0] m_t1  [80];
    logic [63:0] m_fin [4];
    logic [63:0] m_ff  [4];

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        if (m512) return (x >> n) | (x << (64 - n));
        return ((x >> n) | (x << (32 - n))) & 64'h0000_0000_ffff_ffff;
    endfunction

    function automatic logic [63:0] bsig0(input logic [63:0] x);
        if (m512) return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [63:0] bsig1(input logic [63:0] x);
        if (m512) return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [63:0] ssig0(input logic [63:0] x);
        if (m512) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [63:0] ssig1(input logic [63:0] x);
        if (m512) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model(input bit is512, input int nr);
        logic [63:0] w [80];
        logic [63:0] v [8];
        logic [63:0] iv [8];
        logic [63:0] mk, k, t1v, t2v;
        m512 = is512;
        mk   = is512 ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
        for (int i = 0; i < 80; i++) w[i] = 64'h0;
        w[0]  = is512 ? 64'h6162_6380_0000_0000 : 64'h0000_0000_6162_6380;
        w[15] = 64'h18;
        for (int i = 16; i < 80; i++)
            w[i] = (ssig1(w[i-2]) + w[i-7] + ssig0(w[i-15]) + w[i-16]) & mk;
        for (int i = 0; i < 8; i++) begin
            if (is512) iv[i] = IV512[i];
            else       iv[i] = {32'b0, IV256[i]};
            v[i] = iv[i];
        end
        for (int r = 0; r < nr; r++) begin
            if (is512) k = K512[r];
            else       k = {32'b0, K256[r]};
            m_kw[r] = (k + w[r]) & mk;
            m_d[r]  = v[3];
            t1v = (v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + m_kw[r]) & mk;
            t2v = (bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]))) & mk;
            m_t1[r] = t1v;
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = (v[3] + t1v) & mk;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = (t1v + t2v) & mk;
        end
        for (int i = 0; i < 4; i++) begin
            m_fin[i] = v[4+i];
            m_ff[i]  = (v[4+i] + iv[4+i]) & mk;
        end
    endtask

    function automatic logic [255:0] exp_efgh();
        logic [63:0] q [4];
        for (int i = 0; i < 4; i++) begin
`ifdef EFGH_FEEDFORWARD_EN
            q[i] = m_ff[i];
`else
            q[i] = m_fin[i];
`endif
        end
        if (m512) return {q[0], q[1], q[2], q[3]};
        return {128'b0, q[0][31:0], q[1][31:0], q[2][31:0], q[3][31:0]};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_init(input int s);
        if (s == 1) init = {IV512[4], IV512[5], IV512[6], IV512[7]};
        else        init = {128'b0, IV256[4], IV256[5], IV256[6], IV256[7]};
    endtask

    // Runs one block on instance s; abort_after>0 returns right after that many beats.
    // poke drives start during a RUN gap and start/kw_valid during the DONE cycle.
    task automatic run_block(input int s, input int nr, input int abort_after, input bit poke);
        int gap;
        sel = s;
        load_init(s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", busy_s, 1);
        check("start_ready", rdy_s, 1);
        for (int r = 0; r < nr; r++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                kw_valid = 1'b0;
                start    = poke && (g == 0);
                @(posedge clk); #1;
                start = 1'b0;
                check("gap_t1_valid", t1v_s, 0);
                check("gap_ready", rdy_s, 1);
            end
            kw_valid = 1'b1;
            kw       = m_kw[r];
            dw       = m_d[r];
            @(posedge clk); #1;
            kw_valid = 1'b0;
            check("t1_valid", t1v_s, 1);
            check("t1", t1_s, m_t1[r]);
            check("round_idx", idx_s, r);
            if (s == 0 && r == 0) begin
                check("vec0_t1", t1_s, 64'h54da50e8);
                check("vec0_e", dut_a.e_q, 32'hfa2a4622);
                check("vec0_f", dut_a.f_q, 32'h510e527f);
            end
            if (r == nr - 1) begin
                check("done", done_s, 1);
                check("done_ready", rdy_s, 0);
                check("done_busy", busy_s, 1);
                check("efgh_out", efgh_s, exp_efgh());
            end else begin
                check("no_early_done", done_s, 0);
            end
            if (r + 1 == abort_after) return;
        end
        start    = poke;
        kw_valid = poke;
        @(posedge clk); #1;
        start    = 1'b0;
        kw_valid = 1'b0;
        check("idle_after_done", busy_s, 0);
        check("done_one_cycle", done_s, 0);
        check("no_t1_after_done", t1v_s, 0);
        check("efgh_held", efgh_s, exp_efgh());
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sel      = 0;
        start    = 1'b0;
        kw_valid = 1'b0;
        kw       = '0;
        dw       = '0;
        init     = '0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_t1_valid", a_t1v, 0);
        check("rst_done", a_done, 0);
        check("rst_busy", a_busy, 0);
        check("rst_ready", a_ready, 0);
        check("rst_t1", a_t1, 0);
        check("rst_round_idx", a_idx, 0);
        check("rst_efgh", a_efgh, 0);
        rst = 1'b0;

        // Beats offered while idle are ignored.
        kw_valid = 1'b1;
        kw       = 64'ha3ec9318;
        dw       = 64'ha54ff53a;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_ready", a_ready, 0);
            check("idle_t1_valid", a_t1v, 0);
            check("idle_busy", a_busy, 0);
        end
        kw_valid = 1'b0;

        // SHA-256 "abc" with gaps and start pokes during RUN and DONE.
        build_model(1'b0, 64);
        run_block(0, 64, 0, 1'b1);

        // Abandon a block after beat 10 with an asynchronous reset.
        run_block(0, 64, 10, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("abort_t1_valid", a_t1v, 0);
        check("abort_t1", a_t1, 0);
        check("abort_round_idx", a_idx, 0);
        check("abort_busy", a_busy, 0);
        check("abort_efgh", a_efgh, 0);
        #1 rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("abort_no_done", a_done, 0);
            check("abort_idle", a_busy, 0);
        end
        run_block(0, 64, 0, 1'b0);
`ifdef EFGH_FEEDFORWARD_EN
        check("sha256_digest", efgh_s, {128'b0, 128'hb00361a3_96177a9c_b410ff61_f20015ad});
`endif

        // SHA-512 "abc", 80 rounds.
        build_model(1'b1, 80);
        run_block(1, 80, 0, 1'b1);
`ifdef EFGH_FEEDFORWARD_EN
        check("sha512_digest", efgh_s, {64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
                                        64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f});
`endif

        // NROUNDS=1: single beat, then back-to-back start two cycles later.
        build_model(1'b0, 1);
        sel = 2;
        load_init(2);
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        kw_valid = 1'b1;
        kw       = m_kw[0];
        dw       = m_d[0];
        @(posedge clk); #1;
        kw_valid = 1'b0;
        check("n1_t1_valid", c_t1v, 1);
        check("n1_done", c_done, 1);
        check("n1_t1", c_t1, 32'h54da50e8);
        check("n1_round_idx", c_idx, 0);
        check("n1_efgh", efgh_s, exp_efgh());
        start = 1'b1;
        @(posedge clk); #1;
        check("n1_start_in_done_ignored", c_busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("n1_restart_busy", c_busy, 1);
        check("n1_restart_ready", c_ready, 1);
        kw_valid = 1'b1;
        @(posedge clk); #1;
        kw_valid = 1'b0;
        check("n1_second_done", c_done, 1);
        check("n1_second_t1", c_t1, 32'h54da50e8);
        @(posedge clk); #1;
        check("n1_second_idle", c_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
